spi_slave_core: RTL and testbench
=================================

// Module: spi_slave_core
// PURPOSE
// - SPI slave endpoint driven by the spi_topmodule master: consumes ss/sclk/mosi, drives miso.
// - Mode 0 (CPOL=0, CPHA=0), MSB first; mosi sampled on sclk rise, miso updated on sclk fall.
// - SPI pins are oversampled in the system clock domain: no logic is clocked by sclk.
// - Byte-level rx/tx handshakes to local logic; multi-byte frames while ss is held low.
// PARAMETERS
// - DATA_WIDTH   8      bits per SPI word
// - SYNC_STAGES  2      flop stages of the synchroniser on ss, sclk and mosi (>=2)
// - DEFAULT_TX   8'h00  word shifted out when no tx word is buffered (underrun)
// PORTS
// - clk          in   1           system clock
// - rst          in   1           asynchronous active-low reset
// - ss           in   1           slave select, active low, asynchronous to clk
// - sclk         in   1           SPI clock from master, asynchronous to clk
// - mosi         in   1           master-out data
// - miso         out  1           slave-out data; 0 while ss high
// - tx_data      in   DATA_WIDTH  next word to transmit
// - tx_valid     in   1           tx_data valid
// - tx_ready     out  1           tx buffer empty; transfer when tx_valid & tx_ready
// - rx_data      out  DATA_WIDTH  last complete received word, held until next word
// - rx_valid     out  1           1-cycle pulse: rx_data updated
// - busy         out  1           frame in progress (synchronised ss low)
// - tx_underrun  out  1           1-cycle pulse: DEFAULT_TX loaded because buffer empty
// - frame_err    out  1           1-cycle pulse: ss rose with bit_cnt != 0
// BEHAVIOUR
// - Reset (rst=0, async): miso=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0,
//   tx_underrun=0, frame_err=0, tx buffer empty, bit_cnt=0, state IDLE.
// - ss/sclk/mosi pass through SYNC_STAGES flops; edges detected on synchronised copies.
// - Required sclk period >= 8 clk periods; sclk high and low phases >= 4 clk each.
// - FSM IDLE -> ACTIVE on synchronised ss fall; ACTIVE -> IDLE on synchronised ss rise.
// - Entering ACTIVE: tx shift reg <= buffer (buffer emptied, tx_ready=1 next cycle) or
//   DEFAULT_TX with tx_underrun pulse; miso = shift reg MSB in the same cycle.
// - ACTIVE, sclk rise: rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_sync}; bit_cnt++.
// - bit_cnt wraps DATA_WIDTH-1 -> 0: next cycle rx_data <= assembled word, rx_valid=1.
// - ACTIVE, sclk fall, bit_cnt != 0: tx shift left by 1, miso <= new MSB.
// - ACTIVE, sclk fall, bit_cnt == 0 (word boundary): reload tx shift reg as on ACTIVE entry.
// - No rx backpressure: unread rx_data is overwritten by the next word.
// - tx buffer: written when tx_valid & tx_ready; tx_ready=0 from the next cycle until loaded.
//   Write and load in the same cycle: the load takes the old content (or DEFAULT_TX if
//   empty); the new word stays buffered.
// - ss rise mid-word: partial word discarded, no rx_valid, frame_err pulse, bit_cnt=0,
//   miso=0; a word already loaded into the tx shift reg is lost; buffered word kept.
// - ss rise with bit_cnt == 0: clean end, no pulses.
// - sclk edges while IDLE are ignored; async reset mid-frame returns to the reset state
//   and discards all data.
// - busy mirrors the FSM state (1 in ACTIVE).
// TESTING
// - Preload tx 8'hCA, master sends 8'hAD -> rx_data=8'hAD with one rx_valid pulse;
//   master data_out=8'hCA; no tx_underrun, no frame_err.
// - Empty tx buffer, master sends 8'h3C -> master receives 8'h00, one tx_underrun pulse
//   at ss fall, rx_data=8'h3C.
// - 3-byte frame with ss held low, tx 8'h11,8'h22,8'h33 written on each tx_ready,
//   mosi 8'hA1,8'hB2,8'hC3 -> three rx_valid pulses in order; master gets 11,22,33.
// - ss raised after 5 sclk rises -> frame_err pulse, no rx_valid, rx_data unchanged;
//   next full frame with 8'h5A -> rx_data=8'h5A.
// - rst=0 for 2 cycles mid-byte -> every output at its reset value; next frame 8'hF0
//   -> rx_data=8'hF0, miso carries DEFAULT_TX.
// - sclk at exactly clk/8 with 8'hFF/8'h00 alternating -> zero bit errors over 16 words.

Source files
------------

// File: rtl/spi_slave_core.sv
// -----------------------------------------------------------------------------
// spi_slave_core
//
// SPI mode-0 slave endpoint (CPOL=0, CPHA=0, MSB first). The SPI pins are
// oversampled in the system clock domain; nothing is clocked by sclk. mosi is
// captured on each synchronised sclk rise and miso advances on each
// synchronised sclk fall. Several words can be exchanged while ss stays low.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous reset, active low
//   ss           in   slave select, active low, asynchronous to clk
//   sclk         in   SPI clock from the master, asynchronous to clk
//   mosi         in   master-out data
//   miso         out  slave-out data, 0 while no frame is active
//   tx_data      in   next word to transmit
//   tx_valid     in   tx_data valid
//   tx_ready     out  tx buffer empty; word accepted on tx_valid & tx_ready
//   rx_data      out  last complete received word, held until the next one
//   rx_valid     out  1-cycle pulse when rx_data is updated
//   busy         out  frame in progress
//   tx_underrun  out  1-cycle pulse when DEFAULT_TX is loaded (buffer empty)
//   frame_err    out  1-cycle pulse when ss rises in the middle of a word
//
// The master must keep sclk high and low for at least 4 clk each, which
// leaves room for the synchroniser latency before miso must be stable.
// -----------------------------------------------------------------------------
module spi_slave_core #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun,
  output logic                  frame_err
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Pin synchronisers. Bits enter at index 0 and leave at the top index.
  // ss idles high, so its chain resets to ones: releasing reset while the
  // master holds ss high must not look like a frame start.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic                   ss_q, sclk_q;

  // NOTE: every register in a clocked block takes <=, so all flops see the
  // values from before the edge and the block order does not matter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_q      <= 1'b1;
      sclk_q    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_q      <= ss_sync[SYNC_STAGES-1];
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  logic ss_s, sclk_s, mosi_s;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  // mosi has the same latency as sclk, so on a detected rise it is the value
  // the master presented at that rise.
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_fall   = ss_q & ~ss_s;
  assign ss_rise   = ~ss_q & ss_s;
  assign sclk_rise = ~sclk_q & sclk_s;
  assign sclk_fall = sclk_q & ~sclk_s;

  // ---------------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [CW-1:0]         bit_cnt;

  // ---------------------------------------------------------------------------
  // FSM next state and per-cycle strobes
  // ---------------------------------------------------------------------------
  logic load;       // tx shift register takes the buffer (or DEFAULT_TX)
  logic end_frame;  // ss went high during a frame
  logic sample;     // capture one mosi bit
  logic shift;      // advance miso to the next bit

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would make synthesis infer a latch.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    end_frame = 1'b0;
    sample    = 1'b0;
    shift     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // sclk activity without ss is ignored.
        if (ss_fall) begin
          state_d = ACTIVE;
          load    = 1'b1;
        end
      end
      ACTIVE: begin
        // ss release wins over any sclk edge seen in the same cycle.
        if (ss_rise) begin
          state_d   = IDLE;
          end_frame = 1'b1;
        end else begin
          sample = sclk_rise;
          // A fall after the last bit of a word is the word boundary: fetch
          // the next tx word instead of shifting.
          load   = sclk_fall && (bit_cnt == '0);
          shift  = sclk_fall && (bit_cnt != '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the data registers are reset along with the control flops, so a
  // reset mid-frame leaves no stale word that could be sent or reported.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tx_shift    <= '0;
      buf_data    <= '0;
      buf_full    <= 1'b0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      bit_cnt     <= '0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_valid    <= 1'b0;
      tx_underrun <= load & ~buf_full;
      frame_err   <= end_frame & (bit_cnt != '0);

      // tx buffer: writes are only accepted while empty, so a write in the
      // same cycle as a load leaves the load taking the old (empty) state
      // and the new word stays buffered.
      if (tx_valid && !buf_full) begin
        buf_data <= tx_data;
        buf_full <= 1'b1;
      end else if (load) begin
        buf_full <= 1'b0;
      end

      if (load) begin
        tx_shift <= buf_full ? buf_data : DEFAULT_TX;
      end else if (shift) begin
        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      end

      if (end_frame) begin
        bit_cnt <= '0;
      end else if (sample) begin
        rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
        if (bit_cnt == LAST_BIT) begin
          bit_cnt  <= '0;
          rx_data  <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
          rx_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy     = (state_q == ACTIVE);
  assign miso     = busy & tx_shift[DATA_WIDTH-1];
  assign tx_ready = ~buf_full;

endmodule

// File: tb/tb_spi_slave_core.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_core
//
// Mode-0 SPI master model driving spi_slave_core. Single-word frames come
// from a vector table; multi-word, aborted-frame, reset and full-rate runs
// are written out by hand. A feeder process hands queued tx words to the DUT
// whenever tx_ready is high; monitors count the output pulses.
// -----------------------------------------------------------------------------
module tb_spi_slave_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss, sclk, mosi, miso;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy, tx_underrun, frame_err;

  spi_slave_core #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2),
    .DEFAULT_TX (8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ss         (ss),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .tx_underrun(tx_underrun),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // tx feeder: words appended to tx_words by the main thread are offered one
  // at a time; tx_rd advances on the cycle the DUT accepts one.
  // ---------------------------------------------------------------------------
  logic [7:0] tx_words[64];
  int         tx_total = 0;
  int         tx_rd    = 0;

  initial begin
    tx_valid = 1'b0;
    tx_data  = '0;
    forever begin
      @(negedge clk);
      if (tx_rd < tx_total) begin
        tx_data  = tx_words[tx_rd];
        tx_valid = 1'b1;
        if (tx_ready) tx_rd++;
      end else begin
        tx_valid = 1'b0;
      end
    end
  end

  task automatic push_tx(input logic [7:0] w);
    tx_words[tx_total] = w;
    tx_total++;
  endtask

  // Bounded wait until a word sits in the tx buffer.
  task automatic wait_buf_full(input string name);
    for (int k = 0; k < 50 && tx_ready; k++) @(negedge clk);
    check(name, tx_ready, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Output pulse monitors
  // ---------------------------------------------------------------------------
  int         rx_cnt   = 0;
  int         urun_cnt = 0;
  int         ferr_cnt = 0;
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_log.push_back(rx_data);
    end
    if (tx_underrun) urun_cnt++;
    if (frame_err) ferr_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Mode-0 master. Drives nbits bits from mosi_buf (MSB first), captures miso
  // into miso_buf at each rise. urun_entry counts underrun pulses from ss fall
  // up to the first sclk rise.
  // ---------------------------------------------------------------------------
  logic [7:0] mosi_buf[16];
  logic [7:0] miso_buf[16];
  int         urun_entry;

  task automatic spi_frame(input int nbits, input int half, input bit close);
    int u0;
    u0 = urun_cnt;
    @(negedge clk);
    ss = 1'b0;
    repeat (8) @(negedge clk);
    urun_entry = urun_cnt - u0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mosi_buf[i/8][7-(i%8)];
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      miso_buf[i/8][7-(i%8)] = miso;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
    if (close) begin
      repeat (half) @(negedge clk);
      ss   = 1'b1;
      mosi = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Single-word vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       preload;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
    int         exp_urun;
  } vec_t;

  vec_t vecs[3];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},      miso,        1'b0);
    check({tag, "_rx_data"},   rx_data,     8'h00);
    check({tag, "_rx_valid"},  rx_valid,    1'b0);
    check({tag, "_tx_ready"},  tx_ready,    1'b1);
    check({tag, "_busy"},      busy,        1'b0);
    check({tag, "_underrun"},  tx_underrun, 1'b0);
    check({tag, "_frame_err"}, frame_err,   1'b0);
  endtask

  initial begin
    int rx0, fe0, bit_errs_rx, bit_errs_tx;
    logic [7:0] exp_w;

    vecs[0] = '{preload: 1'b1, tx: 8'hCA, mosi: 8'hAD, exp_rx: 8'hAD, exp_miso: 8'hCA, exp_urun: 0};
    vecs[1] = '{preload: 1'b0, tx: 8'h00, mosi: 8'h3C, exp_rx: 8'h3C, exp_miso: 8'h00, exp_urun: 1};
    vecs[2] = '{preload: 1'b1, tx: 8'h96, mosi: 8'h69, exp_rx: 8'h69, exp_miso: 8'h96, exp_urun: 0};

    ss   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    rst  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // sclk toggling with ss high must be ignored.
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk) sclk = 1'b1;
      repeat (4) @(negedge clk) sclk = 1'b0;
    end
    check("idle_sclk_busy", busy, 1'b0);
    check("idle_sclk_rx", rx_cnt, 0);

    // --- single-word table ---
    for (int v = 0; v < 3; v++) begin
      rx0 = rx_cnt;
      fe0 = ferr_cnt;
      if (vecs[v].preload) begin
        push_tx(vecs[v].tx);
        wait_buf_full($sformatf("v%0d_preload", v));
      end
      mosi_buf[0] = vecs[v].mosi;
      spi_frame(8, 4, 1'b1);
      check($sformatf("v%0d_rx_count", v), rx_cnt - rx0, 1);
      check($sformatf("v%0d_rx_data", v), rx_data, vecs[v].exp_rx);
      check($sformatf("v%0d_miso", v), miso_buf[0], vecs[v].exp_miso);
      check($sformatf("v%0d_urun_entry", v), urun_entry, vecs[v].exp_urun);
      check($sformatf("v%0d_frame_err", v), ferr_cnt - fe0, 0);
    end

    // --- three words in one frame, tx refilled on each tx_ready ---
    rx0 = rx_cnt;
    fe0 = ferr_cnt;
    push_tx(8'h11);
    push_tx(8'h22);
    push_tx(8'h33);
    wait_buf_full("multi_preload");
    mosi_buf[0] = 8'hA1;
    mosi_buf[1] = 8'hB2;
    mosi_buf[2] = 8'hC3;
    spi_frame(24, 4, 1'b1);
    check("multi_rx_count", rx_cnt - rx0, 3);
    check("multi_rx0", rx_log[rx0],     8'hA1);
    check("multi_rx1", rx_log[rx0 + 1], 8'hB2);
    check("multi_rx2", rx_log[rx0 + 2], 8'hC3);
    check("multi_miso0", miso_buf[0], 8'h11);
    check("multi_miso1", miso_buf[1], 8'h22);
    check("multi_miso2", miso_buf[2], 8'h33);
    check("multi_frame_err", ferr_cnt - fe0, 0);

    // --- ss raised after 5 sclk rises ---
    rx0 = rx_cnt;
    fe0 = ferr_cnt;
    mosi_buf[0] = 8'hFF;
    spi_frame(5, 4, 1'b1);
    check("abort_frame_err", ferr_cnt - fe0, 1);
    check("abort_rx_count", rx_cnt - rx0, 0);
    check("abort_rx_data", rx_data, 8'hC3);
    check("abort_miso_idle", miso, 1'b0);
    check("abort_busy", busy, 1'b0);
    rx0 = rx_cnt;
    mosi_buf[0] = 8'h5A;
    spi_frame(8, 4, 1'b1);
    check("after_abort_rx_count", rx_cnt - rx0, 1);
    check("after_abort_rx_data", rx_data, 8'h5A);

    // --- async reset in the middle of a word, with a word still buffered ---
    push_tx(8'h77);
    wait_buf_full("rst_preload0");
    push_tx(8'h88);
    mosi_buf[0] = 8'hAA;
    spi_frame(3, 4, 1'b0);
    check("pre_rst_tx_ready", tx_ready, 1'b0);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    ss   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    rst  = 1'b1;
    repeat (6) @(negedge clk);
    rx0 = rx_cnt;
    mosi_buf[0] = 8'hF0;
    spi_frame(8, 4, 1'b1);
    check("post_rst_rx_count", rx_cnt - rx0, 1);
    check("post_rst_rx_data", rx_data, 8'hF0);
    check("post_rst_miso", miso_buf[0], 8'h00);
    check("post_rst_urun_entry", urun_entry, 1);

    // --- 16 words at sclk = clk/8, alternating FF/00 ---
    rx0 = rx_cnt;
    for (int w = 0; w < 16; w++) begin
      mosi_buf[w] = (w % 2 == 0) ? 8'hFF : 8'h00;
      push_tx((w % 2 == 0) ? 8'h00 : 8'hFF);
    end
    wait_buf_full("stress_preload");
    spi_frame(128, 4, 1'b1);
    bit_errs_rx = 0;
    bit_errs_tx = 0;
    for (int w = 0; w < 16; w++) begin
      exp_w = (w % 2 == 0) ? 8'hFF : 8'h00;
      if (rx0 + w < rx_log.size()) bit_errs_rx += $countones(rx_log[rx0 + w] ^ exp_w);
      else bit_errs_rx += 8;
      bit_errs_tx += $countones(miso_buf[w] ^ ~exp_w);
    end
    check("stress_rx_count", rx_cnt - rx0, 16);
    check("stress_rx_bit_errs", bit_errs_rx, 0);
    check("stress_miso_bit_errs", bit_errs_tx, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the bench always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
